dm_sram_resp: RTL and testbench

- Responder (memory side) of the CPU data-SRAM interface.
- Accepts en/wen/addr/wdata requests from the memory stage and returns data_sram_rdata with fixed 1-cycle latency.
- Backed by a single-port byte-enable word array.
- Writes are posted into a one-entry store buffer and retired on idle port cycles; reads forward from the buffer byte-wise.

---
 rtl/dm_pkg.sv | 36 +++
 rtl/dm_sram_resp_if.sv | 21 ++
 rtl/dm_ram_sp.sv | 26 ++
 rtl/dm_sram_resp.sv | 96 +++++++++
 tb/tb_dm_sram_resp.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-SRAM responder: store-buffer entry,
// buffer FSM states and the byte-lane merge used for both merging and forwarding.
package dm_pkg;

    localparam int DEPTH_LOG2_DEF = 12;

    localparam logic [3:0] WEN_NONE = 4'b0000;
    localparam logic [3:0] WEN_WORD = 4'b1111;

    // Full 30-bit word index; upper bits are zero for any in-range entry.
    typedef logic [29:0] widx_t;

    typedef struct packed {
        widx_t       idx;
        logic [3:0]  wen;
        logic [31:0] data;
    } sb_entry_t;

    typedef enum logic {
        SB_EMPTY,
        SB_FULL
    } sb_state_e;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] w;
        if (be == WEN_WORD) return new_word;
        w = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) w[8*i +: 8] = new_word[8*i +: 8];
        end
        return w;
    endfunction

endpackage

// File: rtl/dm_sram_resp_if.sv
// CPU data-SRAM request/response bundle; master is the memory stage,
// slave is the SRAM responder.
interface dm_sram_resp_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        data_sram_rvalid;
    logic        addr_err;

    modport master (
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata, data_sram_rvalid, addr_err
    );

    modport slave (
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        output data_sram_rdata, data_sram_rvalid, addr_err
    );
endinterface

// File: rtl/dm_ram_sp.sv
// Single-port synchronous word RAM with per-byte write enables and a
// registered read port that updates only on read accesses.
module dm_ram_sp #(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [3:0]            we,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**DEPTH_LOG2];

    // NOTE: no reset on the array or read register; a reset would stop this mapping onto SRAM macros.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
            if (we == 4'b0000) rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dm_sram_resp.sv
// Data-SRAM responder: 1-cycle reads, writes posted into a one-entry store
// buffer that retires on cycles where the single array port is not reading.
module dm_sram_resp
    import dm_pkg::*;
#(
    parameter int DEPTH_LOG2      = DEPTH_LOG2_DEF,
    parameter bit RDATA_IDLE_HOLD = 1'b1
) (
    input  logic           clk,
    input  logic           resetn,
    dm_sram_resp_if.slave  bus,
    output logic           sb_valid
);

    sb_state_e   state_q, state_d;
    sb_entry_t   sb_q, sb_d;
    widx_t       req_idx;
    logic        in_range, rd_req, wr_req, same_idx, retire;
    logic        rvalid_q, err_q;
    logic [3:0]  fwd_be_q;
    logic [31:0] fwd_data_q, ram_q, merged, hold_q;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic        addr_lsb_unused;

    assign addr_lsb_unused = ^bus.data_sram_addr[1:0];

    assign req_idx  = bus.data_sram_addr[31:2];
    assign in_range = (bus.data_sram_addr[31:DEPTH_LOG2+2] == '0);
    assign rd_req   = bus.data_sram_en && (bus.data_sram_wen == WEN_NONE) && in_range;
    assign wr_req   = bus.data_sram_en && (bus.data_sram_wen != WEN_NONE) && in_range;
    assign same_idx = (state_q == SB_FULL) && (sb_q.idx == req_idx);
    // A read owns the port; a same-word write merges instead of retiring.
    assign retire   = (state_q == SB_FULL) && !rd_req && !(wr_req && same_idx);
    assign sb_valid = (state_q == SB_FULL);

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        state_d = state_q;
        sb_d    = sb_q;
        if (wr_req) begin
            state_d = SB_FULL;
            if (same_idx) begin
                sb_d.wen  = sb_q.wen | bus.data_sram_wen;
                sb_d.data = byte_merge(sb_q.data, bus.data_sram_wdata, bus.data_sram_wen);
            end else begin
                sb_d = '{idx: req_idx, wen: bus.data_sram_wen, data: bus.data_sram_wdata};
            end
        end else if (retire) begin
            state_d = SB_EMPTY;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= SB_EMPTY;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= rd_req;
            err_q    <= bus.data_sram_en && !in_range;
            if (rvalid_q) hold_q <= merged;
        end
    end

    always_ff @(posedge clk) begin
        sb_q <= sb_d;
        if (rd_req) begin
            fwd_be_q   <= same_idx ? sb_q.wen : WEN_NONE;
            fwd_data_q <= sb_q.data;
        end
    end

    assign ram_en  = rd_req || retire;
    assign ram_we  = rd_req ? WEN_NONE : sb_q.wen;
    assign ram_idx = rd_req ? req_idx[DEPTH_LOG2-1:0] : sb_q.idx[DEPTH_LOG2-1:0];

    dm_ram_sp #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .idx   (ram_idx),
        .wdata (sb_q.data),
        .rdata (ram_q)
    );

    assign merged               = byte_merge(ram_q, fwd_data_q, fwd_be_q);
    assign bus.data_sram_rdata  = rvalid_q ? merged : (RDATA_IDLE_HOLD ? hold_q : '0);
    assign bus.data_sram_rvalid = rvalid_q;
    assign bus.addr_err         = err_q;

endmodule

// File: tb/tb_dm_sram_resp.sv
// Directed bench for dm_sram_resp: a vector table for the single-cycle
// behaviour plus hand sequences for read starvation and asynchronous reset.
module tb_dm_sram_resp;
    import dm_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    logic sb_valid;

    always #5 clk = ~clk;

    dm_sram_resp_if bus ();

    dm_sram_resp #(.DEPTH_LOG2(12), .RDATA_IDLE_HOLD(1'b1)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus),
        .sb_valid (sb_valid)
    );

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rv;
        logic        chk_rd;
        logic [31:0] rd;
        logic        err;
        logic        sb;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic rv, input logic chk_rd,
                                input logic [31:0] rd, input logic err, input logic sb);
        vec_t v;
        v.en = en; v.wen = wen; v.addr = addr; v.wdata = wdata;
        v.rv = rv; v.chk_rd = chk_rd; v.rd = rd; v.err = err; v.sb = sb;
        return v;
    endfunction

    // Drive a request on the falling edge, then sample just after the next rising edge.
    task automatic req(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata);
        @(negedge clk);
        bus.data_sram_en    = en;
        bus.data_sram_wen   = wen;
        bus.data_sram_addr  = addr;
        bus.data_sram_wdata = wdata;
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn              = 1'b0;
        bus.data_sram_en    = 1'b0;
        bus.data_sram_wen   = WEN_NONE;
        bus.data_sram_addr  = '0;
        bus.data_sram_wdata = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset.rdata",    bus.data_sram_rdata,         32'h0);
        check("reset.rvalid",   {31'b0, bus.data_sram_rvalid}, 32'h0);
        check("reset.addr_err", {31'b0, bus.addr_err},         32'h0);
        check("reset.sb_valid", {31'b0, sb_valid},             32'h0);
        @(negedge clk);
        resetn = 1'b1;

        //            en  wen    addr          wdata         rv chk rdata         err sb
        vecs.push_back(mk(1, 4'hF, 32'h10,       32'hDEADBEEF, 0, 0, 32'h0,        0, 1));
        vecs.push_back(mk(0, 4'h0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0));
        vecs.push_back(mk(1, 4'h0, 32'h10,       32'h0,        1, 1, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(0, 4'h0, 32'h0,        32'h0,        0, 1, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(1, 4'hF, 32'h20,       32'h11223344, 0, 0, 32'h0,        0, 1));
        vecs.push_back(mk(0, 4'h0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0));
        vecs.push_back(mk(1, 4'h2, 32'h20,       32'h0000AA00, 0, 0, 32'h0,        0, 1));
        vecs.push_back(mk(1, 4'h0, 32'h20,       32'h0,        1, 1, 32'h1122AA44, 0, 1));
        vecs.push_back(mk(0, 4'h0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0));
        vecs.push_back(mk(1, 4'h0, 32'h20,       32'h0,        1, 1, 32'h1122AA44, 0, 0));
        vecs.push_back(mk(1, 4'h1, 32'h20,       32'h000000CC, 0, 0, 32'h0,        0, 1));
        vecs.push_back(mk(1, 4'h8, 32'h20,       32'hDD000000, 0, 0, 32'h0,        0, 1));
        vecs.push_back(mk(1, 4'h0, 32'h20,       32'h0,        1, 1, 32'hDD22AACC, 0, 1));
        vecs.push_back(mk(1, 4'hF, 32'h40,       32'h55667788, 0, 0, 32'h0,        0, 1));
        vecs.push_back(mk(1, 4'h0, 32'h20,       32'h0,        1, 1, 32'hDD22AACC, 0, 1));
        vecs.push_back(mk(1, 4'h0, 32'h40,       32'h0,        1, 1, 32'h55667788, 0, 1));
        vecs.push_back(mk(0, 4'h0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0));
        vecs.push_back(mk(1, 4'h0, 32'h40,       32'h0,        1, 1, 32'h55667788, 0, 0));
        vecs.push_back(mk(1, 4'hF, 32'h0,        32'h0BADF00D, 0, 0, 32'h0,        0, 1));
        vecs.push_back(mk(0, 4'h0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0));
        vecs.push_back(mk(1, 4'hF, 32'h00010000, 32'hFFFFFFFF, 0, 0, 32'h0,        1, 0));
        vecs.push_back(mk(1, 4'h0, 32'h0,        32'h0,        1, 1, 32'h0BADF00D, 0, 0));
        vecs.push_back(mk(1, 4'h0, 32'h00010000, 32'h0,        0, 1, 32'h0BADF00D, 1, 0));
        vecs.push_back(mk(0, 4'h0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0));
        vecs.push_back(mk(0, 4'hF, 32'h0,        32'h12345678, 0, 0, 32'h0,        0, 0));
        vecs.push_back(mk(1, 4'h0, 32'h0,        32'h0,        1, 1, 32'h0BADF00D, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            req(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata);
            check($sformatf("v%0d.rvalid", i),   {31'b0, bus.data_sram_rvalid}, {31'b0, vecs[i].rv});
            check($sformatf("v%0d.addr_err", i), {31'b0, bus.addr_err},         {31'b0, vecs[i].err});
            check($sformatf("v%0d.sb_valid", i), {31'b0, sb_valid},             {31'b0, vecs[i].sb});
            if (vecs[i].chk_rd)
                check($sformatf("v%0d.rdata", i), bus.data_sram_rdata, vecs[i].rd);
        end

        // Read starvation: the buffered store must wait out a run of reads.
        req(1'b1, WEN_WORD, 32'h8, 32'hCAFEF00D);
        check("starve.sb_after_wr", {31'b0, sb_valid}, 32'h1);
        for (int i = 0; i < 20; i++) begin
            req(1'b1, WEN_NONE, 32'h10, 32'h0);
            check($sformatf("starve%0d.sb_valid", i), {31'b0, sb_valid}, 32'h1);
            check($sformatf("starve%0d.rdata", i),    bus.data_sram_rdata, 32'hDEADBEEF);
        end
        req(1'b0, WEN_NONE, 32'h0, 32'h0);
        check("starve.sb_retired", {31'b0, sb_valid}, 32'h0);
        req(1'b1, WEN_NONE, 32'h8, 32'h0);
        check("starve.rdata", bus.data_sram_rdata, 32'hCAFEF00D);

        // Asynchronous reset with a store still buffered.
        req(1'b1, WEN_WORD, 32'h30, 32'h30303030);
        req(1'b0, WEN_NONE, 32'h0, 32'h0);
        req(1'b1, WEN_WORD, 32'h30, 32'h99999999);
        check("rst.sb_before", {31'b0, sb_valid}, 32'h1);
        req(1'b1, WEN_NONE, 32'h10, 32'h0);
        check("rst.rvalid_before", {31'b0, bus.data_sram_rvalid}, 32'h1);
        #2;
        resetn = 1'b0;
        #1;
        check("rst.rdata",    bus.data_sram_rdata,            32'h0);
        check("rst.rvalid",   {31'b0, bus.data_sram_rvalid},  32'h0);
        check("rst.addr_err", {31'b0, bus.addr_err},          32'h0);
        check("rst.sb_valid", {31'b0, sb_valid},              32'h0);
        @(negedge clk);
        resetn = 1'b1;
        req(1'b0, WEN_NONE, 32'h0, 32'h0);
        req(1'b1, WEN_NONE, 32'h30, 32'h0);
        check("rst.old_rvalid", {31'b0, bus.data_sram_rvalid}, 32'h1);
        check("rst.old_rdata",  bus.data_sram_rdata,           32'h30303030);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
